// File: rtl/alu_op_sequencer.sv
// Handshaked ALU operation sequencer.
// Accepts one operation at a time and runs it: single-cycle bitwise/add/sub/slt,
// or a 32-step unsigned shift-add multiply. The registered result is then held
// until the consumer takes it.
module alu_op_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  localparam int            CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             add_ov_s;
  logic             sub_ov_s;
  logic             slt_s;
  logic [WIDTH-1:0] unit_res_s;
  logic             unit_ov_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;

  // Bitwise units and adder driven from the latched operands; select by latched op.
  always_comb begin
    sum_s      = a_q + b_q;
    diff_s     = a_q + ~b_q + {{(WIDTH-1){1'b0}}, 1'b1};
    add_ov_s   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
    sub_ov_s   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_s[WIDTH-1] != a_q[WIDTH-1]);
    // Signed less-than: sign of the difference, corrected when it overflowed.
    slt_s      = diff_s[WIDTH-1] ^ sub_ov_s;
    unit_res_s = '0;
    unit_ov_s  = 1'b0;
    case (op_q)
      OP_AND: unit_res_s = a_q & b_q;
      OP_OR:  unit_res_s = a_q | b_q;
      OP_XOR: unit_res_s = a_q ^ b_q;
      OP_NOR: unit_res_s = ~(a_q | b_q);
      OP_ADD: begin
        unit_res_s = sum_s;
        unit_ov_s  = add_ov_s;
      end
      OP_SUB: begin
        unit_res_s = diff_s;
        unit_ov_s  = sub_ov_s;
      end
      OP_SLT: unit_res_s = {{(WIDTH-1){1'b0}}, slt_s};
      // MUL never passes through EXEC; keep the unit output quiet.
      default: begin
        unit_res_s = '0;
        unit_ov_s  = 1'b0;
      end
    endcase
  end

  // One shift-add multiply step: conditionally add A into the high half, then shift right.
  always_comb begin
    if (prod_lo_q[0]) begin
      mul_sum_s = {1'b0, prod_hi_q} + {1'b0, a_q};
    end else begin
      mul_sum_s = {1'b0, prod_hi_q};
    end
    mul_hi_s = mul_sum_s[WIDTH:1];
    mul_lo_s = {mul_sum_s[0], prod_lo_q[WIDTH-1:1]};
  end

  // Sequencer next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_hi_d   = prod_hi_q;
    prod_lo_d   = prod_lo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone completes the accept.
        if (in_valid) begin
          op_d = alu_op;
          a_d  = A;
          b_d  = B;
          if (alu_op == OP_MUL) begin
            state_d   = S_MUL;
            prod_hi_d = '0;
            prod_lo_d = B;
            cnt_d     = '0;
          end else begin
            state_d = S_EXEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        result_d    = unit_res_s;
        result_hi_d = '0;
        zero_d      = (unit_res_s == '0);
        overflow_d  = unit_ov_s;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_MUL: begin
        prod_hi_d = mul_hi_s;
        prod_lo_d = mul_lo_s;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          result_d    = mul_lo_s;
          result_hi_d = mul_hi_s;
          zero_d      = (mul_lo_s == '0);
          overflow_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        // Hold the result until the consumer takes it; no same-cycle re-accept.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      a_q         <= '0;
      b_q         <= '0;
      prod_hi_q   <= '0;
      prod_lo_q   <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_hi_q   <= prod_hi_d;
      prod_lo_q   <= prod_lo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

endmodule
